// File: rtl/bit_serial_maj_pkg.sv
// Shared types for the bit-serial majority add/subtract unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bit_serial_maj_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Operation select encoding
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/maj_full_adder.sv
// Single-bit full adder whose carry is the majority of its three inputs.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state.
module maj_full_adder (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic cout
);

    // Sum is odd parity, carry is majority vote
    always_comb begin
        s    = x ^ y ^ c;
        cout = (x & y) | (x & c) | (y & c);
    end

endmodule

// File: rtl/bit_serial_maj_subtractor.sv
// Bit-serial add/subtract (a+b or a+~b+1), one bit per clock, LSB first.
// Latency: accept at T, result valid from T+WIDTH+1; one op per WIDTH+2 cycles.
// Backpressure: result/cb_out held in DONE until out_ready; operands only taken in IDLE.
module bit_serial_maj_subtractor
    import bit_serial_maj_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cb_out
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_shift;
    logic             op_r;
    logic             c_r;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_nxt;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             cb_r;

    // The single arithmetic cell, fed from the operand shift register LSBs
    maj_full_adder u_fa (
        .x    (sa[0]),
        .y    (sb[0]),
        .c    (c_r),
        .s    (sum_bit),
        .cout (carry_nxt)
    );

    // New sum bit enters at the MSB so the LSB-first stream ends up aligned
    always_comb begin
        res_shift            = res_sr >> 1;
        res_shift[WIDTH-1]   = sum_bit;
    end

    // Control FSM with datapath shift registers and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sa          <= '0;
            sb          <= '0;
            res_sr      <= '0;
            op_r        <= OP_ADD;
            c_r         <= 1'b0;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            cb_r        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b with the +1 injected as carry-in
                        sa         <= a;
                        sb         <= (op == OP_SUB) ? ~b : b;
                        op_r       <= op;
                        c_r        <= op;
                        cnt        <= '0;
                        res_sr     <= '0;
                        in_ready_r <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    c_r    <= carry_nxt;
                    res_sr <= res_shift;
                    if (cnt == LAST) begin
                        // Final carry: borrow is its inverse when subtracting
                        cb_r        <= (op_r == OP_SUB) ? ~carry_nxt : carry_nxt;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = res_sr;
    assign cb_out    = cb_r;

endmodule
